sdram_arbiter: RTL
==================

# sdram_arbiter

Request arbiter and refresh scheduler in front of the SDRAM controller. It shares the single controller command path between a client write requester, a client read requester and an internal auto-refresh timer, and issues one operation at a time. It sits between the CPU/bus side and the controller's req/ack handshake, and flags missed refreshes and hung operations.

## Interface
- REF_INTERVAL, 780: cycles between refresh requests (7.8 us at 100 MHz).
- ACK_TIMEOUT, 256: maximum cycles in a service state without an ack.
- clk_100m  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- init_done  in  1  controller power-up init complete; no grants and no refresh counting while low.
- wr_req  in  1  client write request, level, held until wr_done.
- rd_req  in  1  client read request, level, held until rd_done.
- ctrl_wr_req  out  1  write command to controller, level.
- ctrl_rd_req  out  1  read command to controller, level.
- ctrl_ref_req  out  1  auto-refresh command to controller, level.
- ctrl_wr_ack  in  1  one-cycle pulse: write finished.
- ctrl_rd_ack  in  1  one-cycle pulse: read finished.
- ctrl_ref_ack  in  1  one-cycle pulse: refresh finished.
- wr_done  out  1  one-cycle pulse to write client.
- rd_done  out  1  one-cycle pulse to read client.
- ref_pending  out  1  refresh owed and not yet completed.
- ref_miss  out  1  sticky: refresh interval expired while ref_pending already set.
- err_timeout  out  1  sticky: a service state hit ACK_TIMEOUT.

## Operation
- States: S_IDLE, S_REF, S_WR, S_RD. Reset: S_IDLE; all outputs 0; refresh counter, watchdog and last-grant bit 0 (last grant = read, so write wins the first tie).
- Refresh counter: held at 0 while init_done=0; otherwise increments each cycle; at REF_INTERVAL-1 wraps to 0 and sets ref_pending. If ref_pending is already 1 at wrap, set ref_miss instead (still one pending). ctrl_ref_ack in S_REF clears ref_pending. The counter free-runs during all states.
- S_IDLE arbitration (only when init_done=1), in priority order: ref_pending -> S_REF; else write/read round-robin on last-grant bit; single requester wins outright. The last-grant bit updates on entry to S_WR/S_RD.
- Completion masking: in the S_IDLE cycle immediately after a client completion, that client's req is ignored, so a held request cannot be double-served.
- Service state: ctrl_x_req=1 for every cycle in S_x, registered. The matching ack moves the FSM to S_IDLE. Next cycle ctrl_x_req=0 and wr_done/rd_done pulses (none for refresh). Non-matching acks and acks in S_IDLE are ignored.
- Watchdog: cleared on entering a service state, increments each cycle in it. At ACK_TIMEOUT-1 with no ack: go to S_IDLE, set err_timeout, no done pulse, no mask; ref_pending stays set if the state was S_REF.
- init_done falling mid-service does not abort; it is only sampled in S_IDLE. It also clears and holds the refresh counter (ref_pending kept).
- Reset mid-operation: immediate return to reset values; ack pulses during reset are lost.

## Timing
- Grant latency: a request seen in S_IDLE at cycle n gives ctrl_x_req=1 at n+1.
- Ack at cycle n: S_IDLE and done pulse at n+1; next grant ctrl_*_req at n+2 at the earliest. Minimum one idle cycle between operations.
- First ref_pending: REF_INTERVAL cycles after init_done rises (set on the cycle after counter value REF_INTERVAL-1).
- All outputs registered; no combinational path from any input to any output.

## Test plan
- Reset, init_done=1, no client reqs, REF_INTERVAL=780 -> ref_pending at cycle 780, ctrl_ref_req next cycle; ack 10 cycles later -> ctrl_ref_req drops, ref_pending=0.
- wr_req and rd_req held high together, acks 5 cycles after each grant -> grants alternate W,R,W,R. Each done is followed by exactly one idle cycle, and no client is served twice per held request.
- wr_req held continuously, no rd_req -> consecutive writes, one per 7 cycles (5-cycle ack + idle + grant), with wr_done once per write.
- Refresh pending while write in flight -> write completes, then S_REF is granted before the waiting rd_req. Withholding ctrl_ref_ack past a second interval -> ref_miss=1, sticky until rst_n.
- ACK_TIMEOUT=256, grant write, never ack -> ctrl_wr_req high 256 cycles, then low, err_timeout=1, wr_done never pulses, and write is re-granted if wr_req is still high.
- rst_n pulsed low in S_RD -> all outputs 0 asynchronously; after release, no grant until init_done=1, and the refresh counter restarts from 0.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Handshake bundle between the SDRAM arbiter, its clients and the controller.
// The master modport is the arbiter's view; slave is the surrounding system.
interface sdram_arbiter_if;
  logic init_done;
  logic wr_req;
  logic rd_req;
  logic ctrl_wr_req;
  logic ctrl_rd_req;
  logic ctrl_ref_req;
  logic ctrl_wr_ack;
  logic ctrl_rd_ack;
  logic ctrl_ref_ack;
  logic wr_done;
  logic rd_done;
  logic ref_pending;
  logic ref_miss;
  logic err_timeout;

  modport master (
    input  init_done, wr_req, rd_req, ctrl_wr_ack, ctrl_rd_ack, ctrl_ref_ack,
    output ctrl_wr_req, ctrl_rd_req, ctrl_ref_req, wr_done, rd_done,
           ref_pending, ref_miss, err_timeout
  );

  modport slave (
    output init_done, wr_req, rd_req, ctrl_wr_ack, ctrl_rd_ack, ctrl_ref_ack,
    input  ctrl_wr_req, ctrl_rd_req, ctrl_ref_req, wr_done, rd_done,
           ref_pending, ref_miss, err_timeout
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller command path between a write client, a read client
// and the auto-refresh timer; one operation at a time, with refresh and ack watchdogs.
module sdram_arbiter #(
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned ACK_TIMEOUT  = 256
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  sdram_arbiter_if.master   bus
);

  localparam int unsigned REF_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int unsigned WD_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_INTERVAL - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REF, S_WR, S_RD} state_t;

  state_t           state;
  logic [REF_W-1:0] ref_cnt;
  logic [WD_W-1:0]  wdog;
  logic             last_wr;
  logic             mask_wr;
  logic             mask_rd;
  logic             ctrl_wr_req_q;
  logic             ctrl_rd_req_q;
  logic             ctrl_ref_req_q;
  logic             wr_done_q;
  logic             rd_done_q;
  logic             ref_pending_q;
  logic             ref_miss_q;
  logic             err_timeout_q;

  logic ref_wrap_c;
  logic ref_done_c;
  logic wd_expire_c;
  logic wr_eff_c;
  logic rd_eff_c;

  assign ref_wrap_c  = bus.init_done && (ref_cnt == REF_LAST);
  assign ref_done_c  = (state == S_REF) && bus.ctrl_ref_ack;
  assign wd_expire_c = (wdog == WD_LAST);
  // A client that just completed is ignored for one idle cycle.
  assign wr_eff_c    = bus.wr_req && !mask_wr;
  assign rd_eff_c    = bus.rd_req && !mask_rd;

  // Refresh interval timer; a wrap with a refresh still owed is a miss.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt       <= '0;
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
    end else begin
      if (!bus.init_done || ref_wrap_c) ref_cnt <= '0;
      else                              ref_cnt <= ref_cnt + REF_W'(1);

      if (ref_wrap_c) begin
        ref_pending_q <= 1'b1;
        if (ref_pending_q && !ref_done_c) ref_miss_q <= 1'b1;
      end else if (ref_done_c) begin
        ref_pending_q <= 1'b0;
      end
    end
  end

  // Arbitration and service FSM.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wdog           <= '0;
      last_wr        <= 1'b0;
      mask_wr        <= 1'b0;
      mask_rd        <= 1'b0;
      ctrl_wr_req_q  <= 1'b0;
      ctrl_rd_req_q  <= 1'b0;
      ctrl_ref_req_q <= 1'b0;
      wr_done_q      <= 1'b0;
      rd_done_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      mask_wr   <= 1'b0;
      mask_rd   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.init_done) begin
            if (ref_pending_q) begin
              state          <= S_REF;
              ctrl_ref_req_q <= 1'b1;
              wdog           <= '0;
            end else if (wr_eff_c && (!rd_eff_c || !last_wr)) begin
              state         <= S_WR;
              ctrl_wr_req_q <= 1'b1;
              last_wr       <= 1'b1;
              wdog          <= '0;
            end else if (rd_eff_c) begin
              state         <= S_RD;
              ctrl_rd_req_q <= 1'b1;
              last_wr       <= 1'b0;
              wdog          <= '0;
            end
          end
        end
        S_REF: begin
          if (bus.ctrl_ref_ack) begin
            state          <= S_IDLE;
            ctrl_ref_req_q <= 1'b0;
          end else if (wd_expire_c) begin
            state          <= S_IDLE;
            ctrl_ref_req_q <= 1'b0;
            err_timeout_q  <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_WR: begin
          if (bus.ctrl_wr_ack) begin
            state         <= S_IDLE;
            ctrl_wr_req_q <= 1'b0;
            wr_done_q     <= 1'b1;
            mask_wr       <= 1'b1;
          end else if (wd_expire_c) begin
            state         <= S_IDLE;
            ctrl_wr_req_q <= 1'b0;
            err_timeout_q <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_RD: begin
          if (bus.ctrl_rd_ack) begin
            state         <= S_IDLE;
            ctrl_rd_req_q <= 1'b0;
            rd_done_q     <= 1'b1;
            mask_rd       <= 1'b1;
          end else if (wd_expire_c) begin
            state         <= S_IDLE;
            ctrl_rd_req_q <= 1'b0;
            err_timeout_q <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl_wr_req  = ctrl_wr_req_q;
  assign bus.ctrl_rd_req  = ctrl_rd_req_q;
  assign bus.ctrl_ref_req = ctrl_ref_req_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.rd_done      = rd_done_q;
  assign bus.ref_pending  = ref_pending_q;
  assign bus.ref_miss     = ref_miss_q;
  assign bus.err_timeout  = err_timeout_q;

endmodule
